mem_port_arbiter: RTL

Two-requester arbiter and sequencer for the single shared memory port of the multi-cycle MIPS core. It accepts word read/write requests from requester 0 (the core's instruction/data port) and requester 1 (a DMA or debug port). It drives the memory with the same registered `mem_addr`/`mem_read`/`mem_write`/`mem_write_data` semantics the core uses today, and returns read data and completion pulses. Arbitration is round-robin and the memory latency is fixed.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter_rr_pick2.sv | 16 +
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default latencies for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  localparam int unsigned RD_LAT_DEF = 3;
  localparam int unsigned WR_LAT_DEF = 1;

  typedef logic req_idx_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational round-robin picker for two requesters; on a tie the one
// that was not granted last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic idx
);

  assign valid = req0 | req1;
  assign idx   = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer driving the single shared memory port with
// fixed read/write latencies and per-requester completion pulses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEF,
  parameter int unsigned WR_LAT = WR_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  // state | meaning
  // IDLE  | waiting for a request; the only state that grants
  // RD    | mem_read high, counting RD_LAT cycles
  // WR    | mem_write high, counting WR_LAT cycles
  // DONE  | done pulse cycle; requester updates its request here

  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] RD_LAT_C = CW'(RD_LAT);
  localparam logic [CW-1:0] WR_LAT_C = CW'(WR_LAT);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_idx_t      last_q, last_d;
  req_idx_t      gnt_q, gnt_d;
  logic [31:0]   mem_addr_d, mem_write_data_d, rdata0_d, rdata1_d;
  logic          mem_read_d, mem_write_d, done0_d, done1_d, busy_d;
  logic          pick_valid;
  req_idx_t      pick_idx;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_q         <= 1'b1;
      gnt_q          <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_q         <= last_d;
      gnt_q          <= gnt_d;
      mem_addr       <= mem_addr_d;
      mem_write_data <= mem_write_data_d;
      mem_read       <= mem_read_d;
      mem_write      <= mem_write_d;
      rdata0         <= rdata0_d;
      rdata1         <= rdata1_d;
      done0          <= done0_d;
      done1          <= done1_d;
      busy           <= busy_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    last_d           = last_q;
    gnt_d            = gnt_q;
    mem_addr_d       = mem_addr;
    mem_write_data_d = mem_write_data;
    mem_read_d       = mem_read;
    mem_write_d      = mem_write;
    rdata0_d         = rdata0;
    rdata1_d         = rdata1;
    done0_d          = 1'b0;
    done1_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          mem_addr_d       = pick_idx ? addr1 : addr0;
          mem_write_data_d = pick_idx ? wdata1 : wdata0;
          gnt_d            = pick_idx;
          last_d           = pick_idx;
          cnt_d            = CW'(1);
          if (pick_idx ? we1 : we0) begin
            state_d     = WR;
            mem_write_d = 1'b1;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
          end
        end
      end
      RD: begin
        if (cnt_q == RD_LAT_C) begin
          if (gnt_q) rdata1_d = mem_read_data;
          else       rdata0_d = mem_read_data;
          mem_read_d = 1'b0;
          done0_d    = ~gnt_q;
          done1_d    = gnt_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR: begin
        if (cnt_q == WR_LAT_C) begin
          mem_write_d = 1'b0;
          done0_d     = ~gnt_q;
          done1_d     = gnt_q;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
